// File: rtl/hex_line_receiver.sv
// Line-oriented ASCII hex receiver: accumulates hex digits strobed from a UART
// and commits the value on CR/LF, with backspace, escape and error handling.
module hex_line_receiver #(
    parameter int MAX_DIGITS = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_end,
    output logic [31:0] o_accum,
    output logic [31:0] o_value,
    output logic        o_value_valid,
    output logic [3:0]  o_digit_count,
    output logic [7:0]  o_line_count,
    output logic        o_error
);

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_ESC = 8'h1B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] accum_q, accum_d;
    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  lines_q, lines_d;
    logic        err_q,   err_d;

    // Returns {is_hex, nibble} for an ASCII byte.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    logic [4:0] dec;
    logic       is_hex;
    logic [3:0] nibble;
    logic       is_term;

    assign dec     = hex_decode(i_rx_data);
    assign is_hex  = dec[4];
    assign nibble  = dec[3:0];
    assign is_term = (i_rx_data == CH_CR) || (i_rx_data == CH_LF);

    always_comb begin
        state_d = state_q;
        accum_d = accum_q;
        value_d = value_q;
        valid_d = 1'b0;
        count_d = count_q;
        lines_d = lines_q;
        err_d   = err_q;

        if (i_rx_end) begin
            if (i_rx_data == CH_ESC) begin
                accum_d = 32'd0;
                count_d = 4'd0;
                err_d   = 1'b0;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE, ACCUM: begin
                        if (is_hex) begin
                            if (count_q == MAX_D) begin
                                accum_d = 32'd0;
                                count_d = 4'd0;
                                err_d   = 1'b1;
                                state_d = DISCARD;
                            end else begin
                                accum_d = {accum_q[27:0], nibble};
                                count_d = count_q + 4'd1;
                                state_d = ACCUM;
                            end
                        end else if (is_term) begin
                            // Empty lines (and the LF of CR LF) arrive in IDLE and are dropped.
                            if (state_q == ACCUM) begin
                                value_d = accum_q;
                                valid_d = 1'b1;
                                lines_d = lines_q + 8'd1;
                                err_d   = 1'b0;
                                accum_d = 32'd0;
                                count_d = 4'd0;
                                state_d = IDLE;
                            end
                        end else if (i_rx_data == CH_SP && state_q == IDLE) begin
                            state_d = IDLE;
                        end else if (i_rx_data == CH_BS) begin
                            if (state_q == ACCUM) begin
                                accum_d = accum_q >> 4;
                                count_d = count_q - 4'd1;
                                if (count_q == 4'd1) begin
                                    state_d = IDLE;
                                end
                            end
                        end else begin
                            accum_d = 32'd0;
                            count_d = 4'd0;
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (is_term) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Reset wins over a coincident strobe, so a partial line is never committed.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            accum_q <= 32'd0;
            value_q <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 4'd0;
            lines_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            accum_q <= accum_d;
            value_q <= value_d;
            valid_q <= valid_d;
            count_q <= count_d;
            lines_q <= lines_d;
            err_q   <= err_d;
        end
    end

    assign o_accum       = accum_q;
    assign o_value       = value_q;
    assign o_value_valid = valid_q;
    assign o_digit_count = count_q;
    assign o_line_count  = lines_q;
    assign o_error       = err_q;

endmodule
